// File: rtl/ex_pkg.sv
//==============================================================================
// Module      : ex_pkg
// Description : Shared types and constants for the execute-stage issue control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ex_pkg;

  localparam int EX_DATA_W = 16;
  localparam int EX_UOP_W  = 26;
  localparam int EX_OPC_W  = 5;
  localparam int EX_REG_W  = 3;
  localparam int EX_DISP_W = 11;
  localparam int EX_CNT_W  = 16;

  localparam logic [EX_OPC_W-1:0] EX_HALT_OPC = 5'b00000;

  typedef struct packed {
    logic [EX_DATA_W-1:0] inst;
    logic [EX_OPC_W-1:0]  opcode;
    logic [EX_UOP_W-1:0]  uop_cnt;
    logic [EX_REG_W-1:0]  rs;
    logic [EX_REG_W-1:0]  rt;
    logic [EX_DATA_W-1:0] pc;
    logic                 ldst;
    logic                 jmp;
    logic                 branch;
    logic [EX_DISP_W-1:0] jmp_disp;
    logic                 rot_right;
    logic [EX_REG_W-1:0]  dest_reg;
    logic                 reg_write;
  } idix_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } ex_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [EX_CNT_W-1:0] sat_inc(input logic [EX_CNT_W-1:0] v);
    return (v == {EX_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_branch_stats.sv
//==============================================================================
// Module      : ex_branch_stats
// Description : Saturating counters of retired branches and taken branches.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_branch_stats
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_retire,
  input  logic                i_branch,
  input  logic                i_cond,
  output logic [EX_CNT_W-1:0] o_total,
  output logic [EX_CNT_W-1:0] o_taken
);

  logic [EX_CNT_W-1:0] r_total;
  logic [EX_CNT_W-1:0] r_taken;
  logic                w_br_ret;

  assign w_br_ret = i_retire & i_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
      r_taken <= '0;
    end else begin
      if (w_br_ret)
        r_total <= sat_inc(r_total);
      if (w_br_ret & i_cond)
        r_taken <= sat_inc(r_taken);
    end
  end

  assign o_total = r_total;
  assign o_taken = r_taken;

endmodule

`default_nettype wire

// File: rtl/ex_issue_ctrl.sv
//==============================================================================
// Module      : ex_issue_ctrl
// Description : Execute-stage sequencer: ID/EX register, branch/jump redirect,
//               sticky halt. Branch statistics built when EX_BRANCH_STATS_EN
//               is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int                  DATA_W   = EX_DATA_W,
  parameter logic [EX_OPC_W-1:0] HALT_OPC = EX_HALT_OPC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  idix_t               id_uop,
  output idix_t               idix_p1,
  output logic                ex_valid_p1,
  input  logic [DATA_W-1:0]   alu_output_data,
  input  logic [DATA_W-1:0]   pc_nxt_p1,
  input  logic                mem_ready,
  output logic                ex_mem_valid,
  output logic                flush,
  output logic [DATA_W-1:0]   redirect_pc,
  output logic                halted,
  output logic [EX_CNT_W-1:0] br_total_cnt,
  output logic [EX_CNT_W-1:0] br_taken_cnt
);

  ex_state_e         r_state;
  ex_state_e         w_state_nxt;
  idix_t             r_idix;
  logic              r_ex_valid;
  logic [DATA_W-1:0] r_redirect_pc;

  logic w_retire;
  logic w_taken;
  logic w_halt_ret;
  logic w_capture;
  logic w_unused;

  assign w_retire   = r_ex_valid & mem_ready;
  assign w_taken    = w_retire & (r_idix.jmp | (r_idix.branch & alu_output_data[0]));
  assign w_halt_ret = w_retire & (r_idix.opcode == HALT_OPC);

  // Refuse new work while a redirect or halt is retiring so no wrong-path op enters.
  assign id_ready  = ~rst & (r_state == RUN) & (~r_ex_valid | mem_ready)
                   & ~w_taken & ~w_halt_ret;
  assign w_capture = id_valid & id_ready;

  // Halt wins over a taken transfer so a halting instruction never flushes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_halt_ret)
          w_state_nxt = HALT;
        else if (w_taken)
          w_state_nxt = FLUSH;
      end
      FLUSH:   w_state_nxt = RUN;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_idix        <= '0;
      r_ex_valid    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_idix     <= id_uop;
        r_ex_valid <= 1'b1;
      end else if (w_retire) begin
        r_ex_valid <= 1'b0;
      end
      if (w_taken & ~w_halt_ret)
        r_redirect_pc <= pc_nxt_p1;
    end
  end

  assign idix_p1      = r_idix;
  assign ex_valid_p1  = r_ex_valid;
  assign ex_mem_valid = r_ex_valid;
  assign flush        = (r_state == FLUSH);
  assign redirect_pc  = r_redirect_pc;
  assign halted       = (r_state == HALT);

`ifdef EX_BRANCH_STATS_EN
  ex_branch_stats u_branch_stats (
    .clk      (clk),
    .rst      (rst),
    .i_retire (w_retire),
    .i_branch (r_idix.branch),
    .i_cond   (alu_output_data[0]),
    .o_total  (br_total_cnt),
    .o_taken  (br_taken_cnt)
  );
`else
  assign br_total_cnt = '0;
  assign br_taken_cnt = '0;
`endif

  // Only bit 0 of the ALU result carries the branch condition.
  assign w_unused = ^alu_output_data[DATA_W-1:1];

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_ctrl.sv
//==============================================================================
// Module      : tb_ex_issue_ctrl
// Description : Directed self-checking bench for ex_issue_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_issue_ctrl;
  import ex_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  idix_t       id_uop;
  idix_t       idix_p1;
  logic        ex_valid_p1;
  logic [15:0] alu_output_data;
  logic [15:0] pc_nxt_p1;
  logic        mem_ready;
  logic        ex_mem_valid;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] br_total_cnt;
  logic [15:0] br_taken_cnt;

  int total = 0;
  int bad   = 0;

  ex_issue_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_uop          (id_uop),
    .idix_p1         (idix_p1),
    .ex_valid_p1     (ex_valid_p1),
    .alu_output_data (alu_output_data),
    .pc_nxt_p1       (pc_nxt_p1),
    .mem_ready       (mem_ready),
    .ex_mem_valid    (ex_mem_valid),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .halted          (halted),
    .br_total_cnt    (br_total_cnt),
    .br_taken_cnt    (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp_tot, input logic [15:0] exp_tak);
`ifdef EX_BRANCH_STATS_EN
    chk({tag, "_total"}, br_total_cnt, exp_tot);
    chk({tag, "_taken"}, br_taken_cnt, exp_tak);
`else
    chk({tag, "_total"}, br_total_cnt, 16'd0);
    chk({tag, "_taken"}, br_taken_cnt, 16'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic idix_t mk(input logic [4:0] opc, input logic [15:0] pc,
                               input logic jmp, input logic br, input logic [15:0] inst);
    idix_t u;
    u           = '0;
    u.inst      = inst;
    u.opcode    = opc;
    u.uop_cnt   = 26'h1 << opc;
    u.rs        = 3'd1;
    u.rt        = 3'd2;
    u.pc        = pc;
    u.jmp       = jmp;
    u.branch    = br;
    u.jmp_disp  = 11'h005;
    u.dest_reg  = 3'd3;
    u.reg_write = ~(jmp | br);
    return u;
  endfunction

  initial begin
    idix_t add1, add2, add3, add4, add5, add6, add7, beqz, bnez, jr, hlt;
    add1 = mk(5'b11011, 16'h0000, 1'b0, 1'b0, 16'hD901);
    add2 = mk(5'b11011, 16'h0002, 1'b0, 1'b0, 16'hD902);
    add3 = mk(5'b11011, 16'h0004, 1'b0, 1'b0, 16'hD903);
    add4 = mk(5'b11011, 16'h0006, 1'b0, 1'b0, 16'hD904);
    beqz = mk(5'b01100, 16'h0008, 1'b0, 1'b1, 16'h6105);
    add5 = mk(5'b11011, 16'h0040, 1'b0, 1'b0, 16'hD905);
    bnez = mk(5'b01101, 16'h0042, 1'b0, 1'b1, 16'h6906);
    add6 = mk(5'b11011, 16'h0044, 1'b0, 1'b0, 16'hD906);
    jr   = mk(5'b00101, 16'h0046, 1'b1, 1'b0, 16'h2907);
    add7 = mk(5'b11011, 16'h1234, 1'b0, 1'b0, 16'hD907);
    hlt  = mk(5'b00000, 16'h1236, 1'b0, 1'b0, 16'h0000);

    rst = 1'b1; id_valid = 1'b0; id_uop = '0; mem_ready = 1'b1;
    alu_output_data = 16'h0000; pc_nxt_p1 = 16'h0000;

    // Reset
    tick();
    #1 chk("rst_id_ready", id_ready, 1'b0);
    tick();
    chk("rst_idix", idix_p1, 88'h0);
    chk("rst_valid", ex_valid_p1, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_redirect", redirect_pc, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk_cnt("rst_cnt", 16'd0, 16'd0);
    rst = 1'b0;
    #1 chk("idle_ready", id_ready, 1'b1);

    // Three back-to-back ADDs
    id_valid = 1'b1; id_uop = add1;
    tick();
    chk("b2b1_valid", ex_valid_p1, 1'b1);
    chk("b2b1_idix", idix_p1, add1);
    id_uop = add2;
    #1 chk("b2b1_ready", id_ready, 1'b1);
    tick();
    chk("b2b2_idix", idix_p1, add2);
    chk("b2b2_memv", ex_mem_valid, 1'b1);
    id_uop = add3;
    #1 chk("b2b2_ready", id_ready, 1'b1);
    tick();
    chk("b2b3_idix", idix_p1, add3);

    // Memory stall for 4 cycles
    id_uop = add4; mem_ready = 1'b0;
    #1 chk("stall_ready0", id_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_idix", idix_p1, add3);
      chk("stall_valid", ex_valid_p1, 1'b1);
      chk("stall_ready", id_ready, 1'b0);
    end
    mem_ready = 1'b1;
    #1 chk("stall_release", id_ready, 1'b1);
    tick();
    chk("post_stall_idix", idix_p1, add4);

    // Taken BEQZ
    id_uop = beqz;
    tick();
    chk("beqz_idix", idix_p1, beqz);
    alu_output_data = 16'h0001; pc_nxt_p1 = 16'h0040; id_uop = add5;
    #1 chk("beqz_ready", id_ready, 1'b0);
    tick();
    chk("beqz_flush", flush, 1'b1);
    chk("beqz_redirect", redirect_pc, 16'h0040);
    chk("beqz_valid", ex_valid_p1, 1'b0);
    chk("beqz_flush_ready", id_ready, 1'b0);
    alu_output_data = 16'h0000;
    tick();
    chk("beqz_flush_end", flush, 1'b0);
    chk("beqz_no_capture", ex_valid_p1, 1'b0);
    chk("beqz_run_ready", id_ready, 1'b1);
    chk_cnt("beqz_cnt", 16'd1, 16'd1);
    tick();
    chk("add5_idix", idix_p1, add5);
    chk("add5_valid", ex_valid_p1, 1'b1);

    // Not-taken BNEZ
    id_uop = bnez;
    tick();
    chk("bnez_idix", idix_p1, bnez);
    alu_output_data = 16'h0000; pc_nxt_p1 = 16'h0080; id_uop = add6;
    #1 chk("bnez_ready", id_ready, 1'b1);
    tick();
    chk("bnez_flush", flush, 1'b0);
    chk("bnez_next_idix", idix_p1, add6);
    chk("bnez_next_valid", ex_valid_p1, 1'b1);
    chk_cnt("bnez_cnt", 16'd2, 16'd1);

    // JR retiring through a 2-cycle stall; target sampled at retire
    id_uop = jr;
    tick();
    chk("jr_idix", idix_p1, jr);
    mem_ready = 1'b0; pc_nxt_p1 = 16'h1111; id_uop = add7;
    #1 chk("jr_stall_ready", id_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("jr_stall_flush", flush, 1'b0);
      chk("jr_stall_idix", idix_p1, jr);
    end
    mem_ready = 1'b1; pc_nxt_p1 = 16'h1234;
    #1 chk("jr_retire_ready", id_ready, 1'b0);
    tick();
    chk("jr_flush", flush, 1'b1);
    chk("jr_redirect", redirect_pc, 16'h1234);
    chk("jr_valid", ex_valid_p1, 1'b0);
    tick();
    chk("jr_flush_end", flush, 1'b0);
    chk_cnt("jr_cnt", 16'd2, 16'd1);

    // HALT then reset 5 cycles later
    id_uop = hlt;
    #1 chk("halt_issue_ready", id_ready, 1'b1);
    tick();
    chk("halt_idix", idix_p1, hlt);
    id_uop = add7;
    #1 chk("halt_ret_ready", id_ready, 1'b0);
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_valid", ex_valid_p1, 1'b0);
    chk("halt_flush", flush, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_sticky", halted, 1'b1);
      chk("halt_ready", id_ready, 1'b0);
      chk("halt_noflush", flush, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; id_valid = 1'b0;
    #1;
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_idix", idix_p1, 88'h0);
    chk("rst2_valid", ex_valid_p1, 1'b0);
    chk("rst2_redirect", redirect_pc, 16'h0000);
    chk("rst2_flush", flush, 1'b0);
    chk("rst2_ready", id_ready, 1'b1);
    chk_cnt("rst2_cnt", 16'd0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
